// File: rtl/nand_cpu_pkg.sv
// nand_cpu_pkg: shared types and constants for the write-back path.
//   DATA_WIDTH     : register data width. It comes from the `DATA_WIDTH macro
//                    normally provided by nand_cpu.svh. A 16-bit default
//                    applies when no definition is present.
//   WB_SOURCES     : number of write-back producers (0 = ALU, 1 = data memory)
//   REG_ADDR_WIDTH : register file address width (16 registers)
//   wb_req_t       : one write-back request as queued and forwarded
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package nand_cpu_pkg;

    localparam int DATA_WIDTH     = `DATA_WIDTH;
    localparam int WB_SOURCES     = 2;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

    typedef struct packed {
        logic                      use_rw;
        logic [REG_ADDR_WIDTH-1:0] rw_addr;
        logic [DATA_WIDTH-1:0]     data;
        logic                      write_ps;
        logic                      ps;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: per-source request queue for the write-back arbiter.
//   clk, n_rst  : clock, asynchronous active-low reset (clears pointers/count)
//   push, din   : enqueue din at the rising edge (caller guarantees !full)
//   pop, dout   : dout is the head entry; pop removes it at the rising edge
//   empty, full : occupancy flags (full means count == DEPTH)
//   entries     : raw storage, one slot per entry, for hazard decode
//   entry_valid : 1 for slots currently holding a queued entry
module wb_fifo
    import nand_cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  push,
    input  logic                  pop,
    input  wb_req_t               din,
    output wb_req_t               dout,
    output logic                  empty,
    output logic                  full,
    output wb_req_t [DEPTH-1:0]   entries,
    output logic    [DEPTH-1:0]   entry_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: slots are only looked at through entry_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= din;
    end

    assign dout  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    // A slot is occupied when its distance from the read pointer (mod DEPTH)
    // is below the current count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
        logic [PTR_W-1:0] offset;
        always_comb begin
            if (PTR_W'(gi) >= rd_ptr_reg) offset = PTR_W'(gi) - rd_ptr_reg;
            else                          offset = PTR_W'(gi + DEPTH) - rd_ptr_reg;
        end
        assign entries[gi]     = mem[gi];
        assign entry_valid[gi] = (CNT_W'(offset) < count_reg);
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU (source 0) and data-memory (source 1) write-back
// requests onto the single register-file write port.
//   clk, n_rst        : clock, asynchronous active-low reset
//   src_valid/ready   : per-source handshake; ready means the queue has room
//   src_use_rw, src_rw_addr, src_data, src_write_ps, src_ps : request payload
//   wb_valid, wb_*    : registered write-port outputs, one cycle per entry
//   pending_rw        : per-register "write still in flight" flags
//   pending_ps        : a ps write is still in flight
// FIFO_DEPTH (2..8) sets the number of entries buffered per source.
module wb_arbiter
    import nand_cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic [WB_SOURCES-1:0]                    src_valid,
    output logic [WB_SOURCES-1:0]                    src_ready,
    input  logic [WB_SOURCES-1:0]                    src_use_rw,
    input  logic [WB_SOURCES-1:0][REG_ADDR_WIDTH-1:0] src_rw_addr,
    input  logic [WB_SOURCES-1:0][DATA_WIDTH-1:0]    src_data,
    input  logic [WB_SOURCES-1:0]                    src_write_ps,
    input  logic [WB_SOURCES-1:0]                    src_ps,
    output logic                                     wb_valid,
    output logic                                     wb_use_rw,
    output logic [REG_ADDR_WIDTH-1:0]                wb_rw_addr,
    output logic [DATA_WIDTH-1:0]                    wb_data,
    output logic                                     wb_write_ps,
    output logic                                     wb_ps,
    output logic [NUM_REGS-1:0]                      pending_rw,
    output logic                                     pending_ps
);

    wb_req_t                   din      [WB_SOURCES];
    wb_req_t                   head     [WB_SOURCES];
    wb_req_t [FIFO_DEPTH-1:0]  entries  [WB_SOURCES];
    logic    [FIFO_DEPTH-1:0]  entry_valid [WB_SOURCES];
    logic [WB_SOURCES-1:0]     empty;
    logic [WB_SOURCES-1:0]     full;
    logic [WB_SOURCES-1:0]     push;
    logic [WB_SOURCES-1:0]     pop;

    logic    grant_valid;
    logic    grant_idx;
    logic    last_grant_reg;
    logic    wb_valid_reg;
    wb_req_t out_reg;

    for (genvar gi = 0; gi < WB_SOURCES; gi++) begin : g_src
        // Ready depends on the current count only; a pop in the same cycle
        // frees space for the following cycle, not this one.
        assign src_ready[gi] = ~full[gi];
        assign push[gi]      = src_valid[gi] & src_ready[gi];
        assign din[gi] = '{use_rw:   src_use_rw[gi],
                           rw_addr:  src_rw_addr[gi],
                           data:     src_data[gi],
                           write_ps: src_write_ps[gi],
                           ps:       src_ps[gi]};

        wb_fifo #(
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .n_rst      (n_rst),
            .push       (push[gi]),
            .pop        (pop[gi]),
            .din        (din[gi]),
            .dout       (head[gi]),
            .empty      (empty[gi]),
            .full       (full[gi]),
            .entries    (entries[gi]),
            .entry_valid(entry_valid[gi])
        );
    end

    // Round-robin between two heads: on a tie the source not granted last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        if (!empty[0] && !empty[1]) begin
            grant_valid = 1'b1;
            grant_idx   = ~last_grant_reg;
        end else if (!empty[0]) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b0;
        end else if (!empty[1]) begin
            grant_valid = 1'b1;
            grant_idx   = 1'b1;
        end
    end

    assign pop = grant_valid ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    // last_grant resets to 1 so that source 0 wins the first tie.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wb_valid_reg   <= 1'b0;
            out_reg        <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            wb_valid_reg <= grant_valid;
            if (grant_valid) begin
                out_reg        <= head[grant_idx];
                last_grant_reg <= grant_idx;
            end
        end
    end

    assign wb_valid    = wb_valid_reg;
    assign wb_use_rw   = out_reg.use_rw;
    assign wb_rw_addr  = out_reg.rw_addr;
    assign wb_data     = out_reg.data;
    assign wb_write_ps = out_reg.write_ps;
    assign wb_ps       = out_reg.ps;

    // Hazard decode: every queued entry plus the one being presented now.
    always_comb begin
        pending_rw = '0;
        pending_ps = 1'b0;
        for (int s = 0; s < WB_SOURCES; s++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (entry_valid[s][e]) begin
                    if (entries[s][e].use_rw)   pending_rw[entries[s][e].rw_addr] = 1'b1;
                    if (entries[s][e].write_ps) pending_ps = 1'b1;
                end
            end
        end
        if (wb_valid_reg) begin
            if (out_reg.use_rw)   pending_rw[out_reg.rw_addr] = 1'b1;
            if (out_reg.write_ps) pending_ps = 1'b1;
        end
    end

endmodule
